// File: rtl/zbin_ht_arbiter.sv
// zbin_ht_arbiter: collects per-z-bin HT/jet counts, scans for the max-HT bin
// and streams that bin's jets out with valid/last framing.
module zbin_ht_arbiter #(
    parameter int NZ     = 8,
    parameter int HT_W   = 9,
    parameter int NUM_W  = 8,
    parameter int JET_W  = 32,
    parameter int ADDR_W = 8,
    parameter int ZSEL_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NZ-1:0]       zbin_done,
    input  logic [NZ*HT_W-1:0]  ht_in,
    input  logic [NZ*NUM_W-1:0] num_in,
    input  logic [NZ*JET_W-1:0] jet_in,
    input  logic                rd_req,
    output logic [ADDR_W-1:0]   jet_addr,
    output logic [JET_W-1:0]    jet_out,
    output logic                jet_valid,
    output logic                jet_last,
    output logic [HT_W-1:0]     ht_max,
    output logic [NUM_W-1:0]    n_max,
    output logic [ZSEL_W-1:0]   z_max,
    output logic                sel_valid,
    output logic                busy,
    output logic                abort
);
    localparam int IW = ZSEL_W + 1;

    typedef enum logic [2:0] {IDLE, COLLECT, SCAN, READY, READ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [NZ-1:0]     done_reg;
    logic [HT_W-1:0]   ht_reg [NZ];
    logic [NUM_W-1:0]  num_reg [NZ];
    logic [IW-1:0]     idx;
    logic [HT_W-1:0]   best_ht, cur_ht;
    logic [ZSEL_W-1:0] best_sel;
    logic [NUM_W-1:0]  best_num, cnt;
    logic [JET_W-1:0]  sel_jet;
    logic              v1, v2, l1, l2, restart, last_addr;

    assign busy      = state != IDLE;
    assign restart   = start && state != IDLE;
    assign last_addr = cnt == n_max - NUM_W'(1);

    always_comb begin
        cur_ht   = '0;
        best_num = '0;
        sel_jet  = '0;
        for (int i = 0; i < NZ; i++) begin
            if (idx == IW'(i)) cur_ht = ht_reg[i];
            if (best_sel == ZSEL_W'(i)) best_num = num_reg[i];
            if (z_max == ZSEL_W'(i)) sel_jet = jet_in[i*JET_W +: JET_W];
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) state_nxt = COLLECT;
        else case (state)
            IDLE:    state_nxt = start ? COLLECT : IDLE;
            COLLECT: state_nxt = &done_reg ? SCAN : COLLECT;
            SCAN:    state_nxt = idx == IW'(NZ) ? READY : SCAN;
            READY:   state_nxt = !rd_req ? READY : (n_max == '0 ? IDLE : READ);
            READ:    state_nxt = last_addr ? DRAIN : READ;
            DRAIN:   state_nxt = (v1 || v2) ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One extra SCAN cycle at idx==NZ registers the winner, giving NZ+2 edges
    // from the last done sample to sel_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done_reg  <= '0;
            for (int i = 0; i < NZ; i++) begin
                ht_reg[i]  <= '0;
                num_reg[i] <= '0;
            end
            idx       <= '0;
            best_ht   <= '0;
            best_sel  <= '0;
            cnt       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            l1        <= 1'b0;
            l2        <= 1'b0;
            jet_addr  <= '0;
            jet_out   <= '0;
            jet_valid <= 1'b0;
            jet_last  <= 1'b0;
            ht_max    <= '0;
            n_max     <= '0;
            z_max     <= '0;
            sel_valid <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            abort     <= restart;
            v1        <= state == READ && !restart;
            l1        <= state == READ && !restart && last_addr;
            v2        <= v1 && !restart;
            l2        <= l1 && !restart;
            jet_valid <= v2 && !restart;
            jet_last  <= l2 && !restart;
            if (v2) jet_out <= sel_jet;
            if (start) begin
                done_reg  <= '0;
                sel_valid <= 1'b0;
                idx       <= '0;
            end else case (state)
                COLLECT: begin
                    idx <= '0;
                    for (int i = 0; i < NZ; i++) begin
                        if (zbin_done[i] && !done_reg[i]) begin
                            ht_reg[i]   <= ht_in[i*HT_W +: HT_W];
                            num_reg[i]  <= num_in[i*NUM_W +: NUM_W];
                            done_reg[i] <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx == IW'(NZ)) begin
                        ht_max    <= best_ht;
                        n_max     <= best_num;
                        z_max     <= best_sel;
                        sel_valid <= 1'b1;
                    end else begin
                        if (idx == '0 || cur_ht > best_ht) begin
                            best_ht  <= cur_ht;
                            best_sel <= ZSEL_W'(idx);
                        end
                        idx <= idx + IW'(1);
                    end
                end
                READY: begin
                    if (rd_req) begin
                        cnt <= '0;
                        if (n_max == '0) sel_valid <= 1'b0;
                    end
                end
                READ: begin
                    jet_addr <= ADDR_W'(cnt);
                    cnt      <= cnt + NUM_W'(1);
                end
                DRAIN: begin
                    if (!v1 && !v2) sel_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_zbin_ht_arbiter.sv
// tb_zbin_ht_arbiter: directed scoreboard bench; stimulus queues expected
// selections, jets and aborts, a negedge monitor pops and compares them.
module tb_zbin_ht_arbiter;
    localparam int NZ = 8, HT_W = 9, NUM_W = 8, JET_W = 32, ADDR_W = 8, ZSEL_W = 4;

    logic clk = 0, reset = 1, start = 0, rd_req = 0;
    logic [NZ-1:0]       zbin_done = '0;
    logic [NZ*HT_W-1:0]  ht_in = '0;
    logic [NZ*NUM_W-1:0] num_in = '0;
    logic [NZ*JET_W-1:0] jet_in = '0;
    logic [ADDR_W-1:0]   jet_addr;
    logic [JET_W-1:0]    jet_out;
    logic                jet_valid, jet_last, sel_valid, busy, abort;
    logic [HT_W-1:0]     ht_max;
    logic [NUM_W-1:0]    n_max;
    logic [ZSEL_W-1:0]   z_max;

    zbin_ht_arbiter #(.NZ(NZ), .HT_W(HT_W), .NUM_W(NUM_W), .JET_W(JET_W),
                      .ADDR_W(ADDR_W), .ZSEL_W(ZSEL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .zbin_done(zbin_done),
        .ht_in(ht_in), .num_in(num_in), .jet_in(jet_in), .rd_req(rd_req),
        .jet_addr(jet_addr), .jet_out(jet_out), .jet_valid(jet_valid),
        .jet_last(jet_last), .ht_max(ht_max), .n_max(n_max), .z_max(z_max),
        .sel_valid(sel_valid), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {int ht; int n; int z; int t;} sel_t;
    typedef struct {logic [31:0] w; bit last; int t;} jet_t;

    sel_t sel_q[$];
    jet_t jet_q[$];
    int   abort_q[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   hv [8];
    int   nv [8];
    logic sel_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Jet memories: word = {B0, bin, 00, addr}, one-cycle read latency.
    always @(posedge clk)
        for (int i = 0; i < NZ; i++) jet_in[i*JET_W +: JET_W] <= {8'hB0, 8'(i), 8'h00, jet_addr};

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        sel_prev <= sel_valid;
        if (!reset) begin
            if (sel_valid && !sel_prev) begin
                if (sel_q.size() == 0) chk("sel_unexpected", 1, 0);
                else begin
                    sel_t s;
                    s = sel_q.pop_front();
                    chk("ht_max", ht_max, s.ht);
                    chk("n_max", n_max, s.n);
                    chk("z_max", z_max, s.z);
                    chk("sel_latency", cyc, s.t);
                end
            end
            if (jet_valid) begin
                if (jet_q.size() == 0) chk("jet_unexpected", 1, 0);
                else begin
                    jet_t j;
                    j = jet_q.pop_front();
                    chk("jet_out", jet_out, j.w);
                    chk("jet_last", jet_last, j.last);
                    chk("jet_cycle", cyc, j.t);
                end
            end
            if (abort) begin
                if (abort_q.size() == 0) chk("abort_unexpected", 1, 0);
                else chk("abort_cycle", cyc, abort_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int i = 0; i < NZ; i++) begin
            ht_in[i*HT_W +: HT_W]    = HT_W'(hv[i]);
            num_in[i*NUM_W +: NUM_W] = NUM_W'(nv[i]);
        end
    endtask

    task automatic pulse_start(input bit exp_abort);
        start = 1;
        if (exp_abort) abort_q.push_back(cyc + 1);
        tick();
        start = 0;
    endtask

    task automatic all_done(input int h, input int n, input int z);
        zbin_done = '1;
        tick();
        sel_q.push_back('{h, n, z, cyc + 10});
        zbin_done = '0;
    endtask

    task automatic wait_sel();
        for (int k = 0; k < 40 && !sel_valid; k++) tick();
        if (!sel_valid) chk("sel_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("idle_busy", busy, 0);
        chk("idle_sel_valid", sel_valid, 0);
    endtask

    task automatic read_out(input int z, input int n);
        int r;
        rd_req = 1;
        tick();
        rd_req = 0;
        r = cyc;
        for (int k = 0; k < n; k++) jet_q.push_back('{{8'hB0, 8'(z), 8'h00, 8'(k)}, k == n - 1, r + 3 + k});
        for (int k = 0; k < n; k++) begin
            tick();
            chk("jet_addr", jet_addr, k);
        end
        wait_idle();
    endtask

    task automatic check_zero();
        chk("z_sel_valid", sel_valid, 0);
        chk("z_busy", busy, 0);
        chk("z_jet_valid", jet_valid, 0);
        chk("z_jet_last", jet_last, 0);
        chk("z_jet_addr", jet_addr, 0);
        chk("z_jet_out", jet_out, 0);
        chk("z_ht_max", ht_max, 0);
        chk("z_n_max", n_max, 0);
        chk("z_z_max", z_max, 0);
        chk("z_abort", abort, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick(); tick();
        check_zero();
        reset = 0;
        tick();

        // tie at HT=40 goes to bin 1
        pulse_start(0);
        hv = '{10, 40, 25, 40, 0, 0, 0, 0};
        nv = '{1, 3, 2, 5, 0, 0, 0, 0};
        apply();
        all_done(40, 3, 1);
        wait_sel();
        read_out(1, 3);

        // staggered done; bins 0 and 7 change HT after latching
        pulse_start(0);
        hv = '{100, 50, 200, 7, 0, 150, 299, 1};
        nv = '{1, 2, 3, 4, 5, 6, 7, 9};
        apply();
        zbin_done = 8'b0000_0001; tick();
        hv[0] = 511; apply();
        zbin_done = 8'b0010_0101; tick();
        zbin_done = 8'b0111_1111; tick();
        hv[7] = 300; apply();
        zbin_done = 8'b1111_1111; tick();
        sel_q.push_back('{300, 9, 7, cyc + 10});
        hv[7] = 1; apply();
        wait_sel();
        zbin_done = '0;
        tick();

        // start and rd_req together in READY: start wins
        start = 1; rd_req = 1;
        abort_q.push_back(cyc + 1);
        tick();
        start = 0; rd_req = 0;
        chk("sw_sel_valid", sel_valid, 0);
        chk("sw_busy", busy, 1);

        // readout z=2, n=4
        hv = '{5, 6, 100, 7, 0, 0, 0, 99};
        nv = '{1, 1, 4, 1, 0, 0, 0, 2};
        apply();
        all_done(100, 4, 2);
        wait_sel();
        read_out(2, 4);

        // n_max=0 readout request
        pulse_start(0);
        hv = '{0, 0, 0, 0, 0, 0, 0, 50};
        nv = '{3, 0, 0, 0, 0, 0, 0, 0};
        apply();
        all_done(50, 0, 7);
        wait_sel();
        rd_req = 1;
        tick();
        rd_req = 0;
        chk("n0_sel_valid", sel_valid, 0);
        chk("n0_busy", busy, 0);
        tick(); tick(); tick();

        // start during READ at the 2nd address
        pulse_start(0);
        hv = '{1, 2, 3, 4, 5, 6, 7, 8};
        nv = '{1, 1, 1, 1, 1, 1, 1, 6};
        apply();
        all_done(8, 6, 7);
        wait_sel();
        rd_req = 1;
        tick();
        rd_req = 0;
        tick();
        chk("ab_addr0", jet_addr, 0);
        tick();
        chk("ab_addr1", jet_addr, 1);
        pulse_start(1);
        chk("ab_jet_valid", jet_valid, 0);
        chk("ab_sel_valid", sel_valid, 0);
        chk("ab_busy", busy, 1);
        tick();
        chk("ab_jet_valid2", jet_valid, 0);
        hv = '{0, 0, 0, 0, 9, 3, 0, 0};
        nv = '{0, 0, 0, 0, 2, 0, 0, 0};
        apply();
        all_done(9, 2, 4);
        wait_sel();
        read_out(4, 2);

        // reset in SCAN, start held high alongside
        pulse_start(0);
        hv = '{3, 3, 3, 3, 3, 3, 3, 3};
        nv = '{7, 1, 1, 1, 1, 1, 1, 1};
        apply();
        zbin_done = '1; tick();
        zbin_done = '0; tick(); tick(); tick();
        reset = 1; start = 1;
        tick();
        check_zero();
        reset = 0; start = 0;
        tick();
        chk("rs_busy", busy, 0);
        chk("rs_abort", abort, 0);
        pulse_start(0);
        all_done(3, 7, 0);
        wait_sel();
        read_out(0, 7);

        tick(); tick();
        chk("sel_q_empty", sel_q.size(), 0);
        chk("jet_q_empty", jet_q.size(), 0);
        chk("abort_q_empty", abort_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/zbin_ht_arbiter.md
Name: zbin_ht_arbiter

Overview:
- Parametrised z-bin arbiter for the track-jet finder; sits downstream of the NZ ZBIN clustering instances.
- Collects each z-bin's L2-done, HT and jet count, and runs a sequential scan to pick the max-HT z-bin.
- Streams that z-bin's jets out with valid/last framing.
- Generalises the fixed 8-input max-select and mux pair: runtime NZ, a handshaked readout, and abort/restart semantics.

Parameters:
NZ, 8, number of z-bins (2..15)
HT_W, 9, HT width per z-bin
NUM_W, 8, jet-count width
JET_W, 32, jet word width
ADDR_W, 8, jet memory address width
ZSEL_W, 4, z-bin index width (must be >= clog2(NZ))

Ports:
clk  in  1  clock
reset  in  1  sync reset
start  in  1  new-event pulse; clears collected state
zbin_done  in  NZ  per-z-bin L2 clustering done (level)
ht_in  in  NZ*HT_W  per-z-bin HT, bin i at [i*HT_W +: HT_W]
num_in  in  NZ*NUM_W  per-z-bin jet count
jet_in  in  NZ*JET_W  per-z-bin jet memory read data, 1-cycle latency from jet_addr
rd_req  in  1  downstream requests readout of selected z-bin
jet_addr  out  ADDR_W  broadcast read address to z-bin jet memories
jet_out  out  JET_W  selected jet word
jet_valid  out  1  jet_out valid
jet_last  out  1  final jet of event
ht_max  out  HT_W  max HT
n_max  out  NUM_W  jet count of max z-bin
z_max  out  ZSEL_W  index of max z-bin
sel_valid  out  1  ht_max/n_max/z_max valid
busy  out  1  state != IDLE
abort  out  1  1-cycle pulse: start received outside IDLE

Behaviour:
- Reset is synchronous, active-high, on clk.
- All outputs reset to 0. State resets to IDLE. done_reg, ht_reg and num_reg reset to 0.
- States: IDLE, COLLECT, SCAN, READY, READ, DRAIN.
- IDLE: start -> COLLECT, clearing done_reg.
- COLLECT: each cycle, for every i with zbin_done[i]=1 and done_reg[i]=0, latch ht_reg[i]=ht_in[i] and num_reg[i]=num_in[i], and set done_reg[i].
  - A later zbin_done assertion does not relatch.
  - When done_reg is all ones -> SCAN with idx=0.
- SCAN: one compare per cycle, idx 0..NZ-1, NZ cycles total.
  - idx=0 loads best_ht=ht_reg[0], best_sel=0 unconditionally.
  - idx>0 replaces the best only if ht_reg[idx] > best_ht (strict), so ties go to the lowest index.
  - After idx=NZ-1 -> READY, with ht_max, n_max=num_reg[best_sel] and z_max registered and sel_valid=1.
- Latency: sel_valid rises exactly NZ+2 clk edges after the edge that samples the last zbin_done bit.
- READY: hold outputs. rd_req -> READ with cnt=0. If n_max=0, rd_req -> IDLE instead, no jet_valid, sel_valid cleared.
- READ:
  - jet_addr=cnt, then cnt increments each cycle until n_max-1 has been issued, then -> DRAIN.
  - The z-bin returns data 1 cycle after the address. jet_out is registered from jet_in[z_max], so jet_valid is asserted 2 cycles after its address.
  - jet_last accompanies the word for address n_max-1.
- DRAIN: wait until the 2-stage valid pipeline is empty -> IDLE, clearing sel_valid.
- rd_req is ignored outside READY.
- start in IDLE is normal; start in any other state pulses abort, flushes the pipeline (jet_valid=0 next cycle), clears done_reg and sel_valid, and -> COLLECT.
- start and rd_req in the same READY cycle: start wins.
- Reset mid-operation returns to IDLE next edge with all outputs 0, regardless of start.
- jet_addr holds its last value outside READ.
- n_max=255 (NUM_W max) streams 255 words with no counter wrap; cnt is NUM_W bits.
- zbin_done bits may arrive in any order or all in one cycle.

Test Plan:
- NZ=8, HT={10,40,25,40,0,0,0,0}, num={1,3,2,5,0,0,0,0}, all done same cycle -> z_max=1 (tie goes to lowest), ht_max=40, n_max=3, sel_valid rises 10 edges after the done sample.
- Staggered done: bin 7 last with HT=300 while bin 7's ht_in changes after its done -> latched 300 is used, z_max=7.
- Readout, z_max=2, n_max=4, rd_req pulse -> jet_addr 0,1,2,3 on consecutive cycles; jet_valid for 4 cycles starting 2 cycles after addr 0; jet_last on the 4th; then IDLE, busy=0.
- n_max=0 with rd_req -> no jet_valid; sel_valid drops next cycle; IDLE.
- start during READ at the 2nd address -> abort pulse, jet_valid=0 next cycle, state COLLECT, sel_valid=0; new event completes correctly.
- reset asserted in SCAN -> all outputs 0 next edge; a following start/done sequence produces a correct selection.
